// File: rtl/rtc_bus_write.sv
// rtl/rtc_bus_write.sv - RTC multiplexed AD-port write-cycle generator.
// Drives one cs_n/wr_n cycle per start with programmable phase lengths, then pulses final_wr.
module rtc_bus_write #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 4,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_REC   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       is_addr,
  input  logic [7:0] din,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       ad_sel,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       busy,
  output logic       final_wr
);

  localparam logic [7:0] L_SETUP = 8'(T_SETUP - 1);
  localparam logic [7:0] L_PULSE = 8'(T_PULSE - 1);
  localparam logic [7:0] L_HOLD  = 8'(T_HOLD - 1);
  localparam logic [7:0] L_REC   = 8'(T_REC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOVER, S_DONE
  } state_t;

  state_t     r_state, w_next;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_bus_q;
  logic       r_addr_q;
  logic       r_cs_n, r_wr_n, r_ad_sel, r_bus_oe, r_busy, r_final_wr;
  logic       w_cs_n, w_wr_n, w_ad_sel, w_bus_oe, w_busy, w_final_wr;
  logic       w_launch, w_addr_nxt;

  assign w_launch   = (r_state == S_IDLE) && start;
  assign w_addr_nxt = w_launch ? is_addr : r_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_bus_q    <= 8'd0;
      r_addr_q   <= 1'b0;
      r_cs_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_ad_sel   <= 1'b0;
      r_bus_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_final_wr <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_nxt;
      r_addr_q   <= w_addr_nxt;
      if (w_launch) r_bus_q <= din;
      r_cs_n     <= w_cs_n;
      r_wr_n     <= w_wr_n;
      r_ad_sel   <= w_ad_sel;
      r_bus_oe   <= w_bus_oe;
      r_busy     <= w_busy;
      r_final_wr <= w_final_wr;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_SETUP;
      S_SETUP:   if (r_cnt == 8'd0) w_next = S_STROBE;
      S_STROBE:  if (r_cnt == 8'd0) w_next = S_HOLD;
      S_HOLD:    if (r_cnt == 8'd0) w_next = S_RECOVER;
      S_RECOVER: if (r_cnt == 8'd0) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Counter reloads on every phase entry and otherwise runs down to zero and parks.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_next != r_state) begin
      case (w_next)
        S_SETUP:   w_cnt_nxt = L_SETUP;
        S_STROBE:  w_cnt_nxt = L_PULSE;
        S_HOLD:    w_cnt_nxt = L_HOLD;
        S_RECOVER: w_cnt_nxt = L_REC;
        default:   w_cnt_nxt = 8'd0;
      endcase
    end else if (r_cnt != 8'd0) begin
      w_cnt_nxt = r_cnt - 8'd1;
    end
  end

  // Outputs decode the state being entered so they register on the same edge.
  always_comb begin
    w_cs_n     = 1'b1;
    w_wr_n     = 1'b1;
    w_bus_oe   = 1'b0;
    w_busy     = (w_next != S_IDLE);
    w_final_wr = 1'b0;
    w_ad_sel   = r_ad_sel;
    case (w_next)
      S_SETUP, S_HOLD: begin
        w_cs_n   = 1'b0;
        w_bus_oe = 1'b1;
        w_ad_sel = ~w_addr_nxt;
      end
      S_STROBE: begin
        w_cs_n   = 1'b0;
        w_wr_n   = 1'b0;
        w_bus_oe = 1'b1;
        w_ad_sel = ~w_addr_nxt;
      end
      S_DONE:  w_final_wr = 1'b1;
      default: ;
    endcase
  end

  assign cs_n     = r_cs_n;
  assign wr_n     = r_wr_n;
  assign rd_n     = 1'b1;
  assign ad_sel   = r_ad_sel;
  assign bus_out  = r_bus_q;
  assign bus_oe   = r_bus_oe;
  assign busy     = r_busy;
  assign final_wr = r_final_wr;

endmodule

// File: tb/tb_rtc_bus_write.sv
// tb/tb_rtc_bus_write.sv - directed-vector bench for rtc_bus_write.
// Instance 0 uses default timing, instance 1 uses all phases of one cycle.
module tb_rtc_bus_write;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start0 = 1'b0, is_addr0 = 1'b0;
  logic [7:0] din0 = 8'h00;
  logic       start1 = 1'b0, is_addr1 = 1'b0;
  logic [7:0] din1 = 8'h00;
  logic       cs_n0, wr_n0, rd_n0, ad_sel0, bus_oe0, busy0, final_wr0;
  logic       cs_n1, wr_n1, rd_n1, ad_sel1, bus_oe1, busy1, final_wr1;
  logic [7:0] bus_out0, bus_out1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rtc_bus_write dut0 (
    .clk(clk), .reset(reset), .start(start0), .is_addr(is_addr0), .din(din0),
    .cs_n(cs_n0), .wr_n(wr_n0), .rd_n(rd_n0), .ad_sel(ad_sel0), .bus_out(bus_out0),
    .bus_oe(bus_oe0), .busy(busy0), .final_wr(final_wr0)
  );

  rtc_bus_write #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_REC(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .is_addr(is_addr1), .din(din1),
    .cs_n(cs_n1), .wr_n(wr_n1), .rd_n(rd_n1), .ad_sel(ad_sel1), .bus_out(bus_out1),
    .bus_oe(bus_oe1), .busy(busy1), .final_wr(final_wr1)
  );

  typedef struct {
    logic       cs_n, wr_n, rd_n, ad_sel, bus_oe, busy, final_wr;
    logic [7:0] bus_out;
  } outs_t;

  typedef struct {
    int         sel;
    logic       is_addr;
    logic [7:0] din;
    logic [7:0] din2;
    bit         keep;
    logic       exp_ad_sel;
    logic [7:0] exp_bus;
  } vec_t;

  typedef struct {
    logic       is_addr;
    logic [7:0] din;
  } step_t;

  function automatic outs_t sample(int sel);
    outs_t o;
    if (sel == 0) begin
      o.cs_n = cs_n0; o.wr_n = wr_n0; o.rd_n = rd_n0; o.ad_sel = ad_sel0;
      o.bus_oe = bus_oe0; o.busy = busy0; o.final_wr = final_wr0; o.bus_out = bus_out0;
    end else begin
      o.cs_n = cs_n1; o.wr_n = wr_n1; o.rd_n = rd_n1; o.ad_sel = ad_sel1;
      o.bus_oe = bus_oe1; o.busy = busy1; o.final_wr = final_wr1; o.bus_out = bus_out1;
    end
    return o;
  endfunction

  task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at k=%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic st, input logic ia, input logic [7:0] d);
    if (sel == 0) begin start0 = st; is_addr0 = ia; din0 = d; end
    else begin start1 = st; is_addr1 = ia; din1 = d; end
  endtask

  // Checks one full write cycle from E0 through the first IDLE cycle after DONE.
  task automatic run_cycle(input vec_t v);
    int s, p, h, r;
    outs_t o;
    logic e_cs, e_wr, e_oe, e_busy, e_fw;
    if (v.sel == 0) begin s = 2; p = 4; h = 2; r = 2; end
    else begin s = 1; p = 1; h = 1; r = 1; end
    set_in(v.sel, 1'b1, v.is_addr, v.din);
    @(posedge clk);
    for (int k = 0; k <= s + p + h + r + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (v.keep) set_in(v.sel, 1'b1, v.is_addr, v.din2);
        else set_in(v.sel, 1'b0, ~v.is_addr, 8'hFF);
      end
      o = sample(v.sel);
      e_cs = 1'b1; e_wr = 1'b1; e_oe = 1'b0; e_busy = 1'b1; e_fw = 1'b0;
      if (k < s + p + h) begin e_cs = 1'b0; e_oe = 1'b1; end
      if (k >= s && k < s + p) e_wr = 1'b0;
      if (k == s + p + h + r) e_fw = 1'b1;
      if (k == s + p + h + r + 1) e_busy = 1'b0;
      chk("cs_n", k, {7'd0, o.cs_n}, {7'd0, e_cs});
      chk("wr_n", k, {7'd0, o.wr_n}, {7'd0, e_wr});
      chk("bus_oe", k, {7'd0, o.bus_oe}, {7'd0, e_oe});
      chk("busy", k, {7'd0, o.busy}, {7'd0, e_busy});
      chk("final_wr", k, {7'd0, o.final_wr}, {7'd0, e_fw});
      chk("rd_n", k, {7'd0, o.rd_n}, 8'd1);
      chk("ad_sel", k, {7'd0, o.ad_sel}, {7'd0, v.exp_ad_sel});
      chk("bus_out", k, o.bus_out, v.exp_bus);
    end
  endtask

  initial begin
    vec_t  vecs[6];
    step_t steps[4];
    outs_t o;
    int    code, pulses;

    vecs[0] = '{0, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b1, 8'hA5};
    vecs[1] = '{0, 1'b1, 8'h0E, 8'h0E, 1'b0, 1'b0, 8'h0E};
    vecs[2] = '{0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b1, 8'hA5};
    vecs[3] = '{0, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b1, 8'h3C};
    vecs[4] = '{1, 1'b1, 8'h5A, 8'hC3, 1'b1, 1'b0, 8'h5A};
    vecs[5] = '{1, 1'b1, 8'hC3, 8'hC3, 1'b0, 1'b0, 8'hC3};
    steps[0] = '{1'b1, 8'h0A};
    steps[1] = '{1'b0, 8'h26};
    steps[2] = '{1'b1, 8'h0B};
    steps[3] = '{1'b0, 8'h82};

    #12;
    o = sample(0);
    chk("rst cs_n", 0, {7'd0, o.cs_n}, 8'd1);
    chk("rst wr_n", 0, {7'd0, o.wr_n}, 8'd1);
    chk("rst rd_n", 0, {7'd0, o.rd_n}, 8'd1);
    chk("rst ad_sel", 0, {7'd0, o.ad_sel}, 8'd0);
    chk("rst bus_out", 0, o.bus_out, 8'h00);
    chk("rst bus_oe", 0, {7'd0, o.bus_oe}, 8'd0);
    chk("rst busy", 0, {7'd0, o.busy}, 8'd0);
    chk("rst final_wr", 0, {7'd0, o.final_wr}, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset asserted mid-STROBE must clear outputs without a clock edge.
    set_in(0, 1'b1, 1'b0, 8'h77);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 1'b0, 8'h77);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre-rst wr_n", 3, {7'd0, wr_n0}, 8'd0);
    reset = 1'b1;
    #1;
    chk("arst wr_n", 3, {7'd0, wr_n0}, 8'd1);
    chk("arst cs_n", 3, {7'd0, cs_n0}, 8'd1);
    chk("arst bus_oe", 3, {7'd0, bus_oe0}, 8'd0);
    chk("arst busy", 3, {7'd0, busy0}, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("idle busy", k, {7'd0, busy0}, 8'd0);
      chk("idle cs_n", k, {7'd0, cs_n0}, 8'd1);
      chk("idle final_wr", k, {7'd0, final_wr0}, 8'd0);
    end

    for (int i = 0; i < 6; i++) run_cycle(vecs[i]);

    // Sequencer model: next code registered on the final_wr edge.
    code = 0;
    pulses = 0;
    set_in(0, 1'b1, steps[0].is_addr, steps[0].din);
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      o = sample(0);
      if (o.final_wr) begin
        if (code < 4) chk("seq bus_out", code, o.bus_out, steps[code].din);
        code++;
        pulses++;
      end
      if (code < 4) set_in(0, 1'b1, steps[code].is_addr, steps[code].din);
      else set_in(0, 1'b0, 1'b0, 8'h00);
    end
    chk("seq pulses", 0, 8'(pulses), 8'd4);
    chk("seq idle busy", 0, {7'd0, busy0}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
